// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N-to-1 multiplexer with valid/ready handshakes on every
// input channel and on the output. One valid channel is granted per transfer,
// chosen round-robin from a rotating pointer (mode=0) or by lowest index
// (mode=1). The granted word is captured into the output register together
// with the index of the channel that supplied it.
//
// Optional feature (macro RR_MUX_FORCE_SEL_EN): adds force_en/force_sel, which
// pin the grant to one channel regardless of mode without moving the pointer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N*WIDTH, channel i in bits [i*WIDTH +: WIDTH]
//   in_valid   N, per-channel valid
//   in_ready   N, per-channel ready (combinational, one-hot or zero)
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   force_en   (RR_MUX_FORCE_SEL_EN only) force the grant to force_sel
//   force_sel  (RR_MUX_FORCE_SEL_EN only) forced channel; values >= N grant nothing
//   out_data   registered selected word
//   out_ch     registered index of the supplying channel
//   out_valid  registered output valid
//   out_ready  downstream ready
module rr_mux_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic               force_en,
  input  logic [CW-1:0]      force_sel,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  // One spare bit so ptr + offset can exceed N-1 before wrapping.
  localparam int unsigned CWX = CW + 1;

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    grant;
  logic             grant_vld;
  logic             load;
  logic             xfer;
  logic             ptr_upd;
  logic [WIDTH-1:0] sel_data;

  // Output register can take a new word when empty or being drained this cycle.
  assign load = !out_valid || out_ready;
  assign xfer = load && grant_vld;

  // Arbitration. Loops run from the lowest-priority candidate upwards so the
  // last hit written is the winner.
  always_comb begin : arb_c
    logic [CWX-1:0] sum;
    logic [CW-1:0]  idx;
    grant     = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant     = CW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int off = N - 1; off >= 0; off--) begin
        sum = CWX'(ptr) + CWX'(off);
        if (sum >= CWX'(N)) begin
          sum = sum - CWX'(N);
        end
        idx = CW'(sum);
        if (in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      grant     = force_sel;
      grant_vld = (CWX'(force_sel) < CWX'(N)) ? in_valid[force_sel] : 1'b0;
    end
`endif
  end

  // Forced transfers leave the round-robin pointer where it was.
`ifdef RR_MUX_FORCE_SEL_EN
  assign ptr_upd = xfer && !force_en;
`else
  assign ptr_upd = xfer;
`endif

  // Ready is raised only on the granted channel.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && grant_vld && (grant == CW'(i));
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == CW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ptr_upd) begin
        ptr <= (grant == CW'(N - 1)) ? '0 : grant + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n: directed scenarios on N=4 and N=3
// instances plus a randomized run on N=4 against a behavioural model.
module tb_rr_mux_n;

  localparam int N4 = 4;
  localparam int N3 = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [N4*W-1:0] d4_data;
  logic [N4-1:0]   d4_valid, d4_ready;
  logic            d4_mode, d4_out_valid, d4_out_ready;
  logic [W-1:0]    d4_out_data;
  logic [1:0]      d4_out_ch;

  logic [N3*W-1:0] d3_data;
  logic [N3-1:0]   d3_valid, d3_ready;
  logic            d3_mode, d3_out_valid, d3_out_ready;
  logic [W-1:0]    d3_out_data;
  logic [1:0]      d3_out_ch;

`ifdef RR_MUX_FORCE_SEL_EN
  logic       f4_en, f3_en;
  logic [1:0] f4_sel, f3_sel;
`endif

  rr_mux_n #(.N(N4), .WIDTH(W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_data), .in_valid(d4_valid),
    .in_ready(d4_ready), .mode(d4_mode),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en(f4_en), .force_sel(f4_sel),
`endif
    .out_data(d4_out_data), .out_ch(d4_out_ch), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready)
  );

  rr_mux_n #(.N(N3), .WIDTH(W)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid),
    .in_ready(d3_ready), .mode(d3_mode),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en(f3_en), .force_sel(f3_sel),
`endif
    .out_data(d3_out_data), .out_ch(d3_out_ch), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the N=4 instance.
  bit         m_ov;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  // Winner = valid channel with the smallest distance from ptr (rr) or index (fixed).
  function automatic int pick(input logic [7:0] v, input logic md, input int p, input int n);
    int best = -1;
    int bd = n;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        int d = md ? i : (i - p + n) % n;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_ready4();
    bit ld = !m_ov || d4_out_ready;
    int g = pick({4'b0, d4_valid}, d4_mode, m_ptr, N4);
    return (ld && g >= 0) ? 4'(1 << g) : 4'b0;
  endfunction

  task automatic model_step4();
    bit ld = !m_ov || d4_out_ready;
    int g = pick({4'b0, d4_valid}, d4_mode, m_ptr, N4);
    if (ld && g >= 0) begin
      m_ov   = 1'b1;
      m_data = d4_data[g*W +: W];
      m_ch   = g;
      m_ptr  = (g + 1) % N4;
    end else if (ld) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic idle_inputs();
    d4_data = '0; d4_valid = '0; d4_mode = 1'b0; d4_out_ready = 1'b1;
    d3_data = '0; d3_valid = '0; d3_mode = 1'b0; d3_out_ready = 1'b1;
`ifdef RR_MUX_FORCE_SEL_EN
    f4_en = 1'b0; f4_sel = '0; f3_en = 1'b0; f3_sel = '0;
`endif
  endtask

  // Leaves the bench at posedge+1 with both DUTs idle and out of reset.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({d4_out_valid, d4_out_data, d4_out_ch} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h ch=%0d want 0", d4_out_valid, d4_out_data, d4_out_ch);
    end
    // Load channel 2 so the pointer moves away from 0 before the reset.
    d4_out_ready = 1'b0;
    d4_valid = 4'b0100;
    for (int i = 0; i < N4; i++) d4_data[i*W +: W] = 8'(8'h10 + i);
    @(negedge clk);
    model_step4();
    @(posedge clk);
    #1;
    checks++;
    if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd2 && d4_out_data === 8'h12)) begin
      errors++;
      $display("FAIL pre_reset_load got v=%b d=%h ch=%0d want v=1 d=12 ch=2", d4_out_valid, d4_out_data, d4_out_ch);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({d4_out_valid, d4_out_data, d4_out_ch} !== 11'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h ch=%0d want 0", d4_out_valid, d4_out_data, d4_out_ch);
    end
    checks++;
    if (int'(u_dut4.ptr) !== 0) begin
      errors++;
      $display("FAIL reset_ptr got %0d want 0", u_dut4.ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d4_valid = 4'hF;
    d4_out_ready = 1'b1;
    #1;
    checks++;
    if (d4_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant_ready got %b want 0001", d4_ready);
    end
    model_step4();
    @(posedge clk);
    #1;
    checks++;
    if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd0 && d4_out_data === 8'h10)) begin
      errors++;
      $display("FAIL first_grant_out got v=%b ch=%0d d=%h want v=1 ch=0 d=10", d4_out_valid, d4_out_ch, d4_out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    d4_valid = 4'hF;
    for (int i = 0; i < N4; i++) d4_data[i*W +: W] = 8'(i);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (d4_ready !== exp_ready4()) begin
        errors++;
        $display("FAIL rr_ready k=%0d got %b want %b", k, d4_ready, exp_ready4());
      end
      model_step4();
      @(posedge clk);
      #1;
      checks++;
      if (!(d4_out_valid === 1'b1 && int'(d4_out_ch) == k % 4 && int'(d4_out_data) == k % 4)) begin
        errors++;
        $display("FAIL rr_seq k=%0d got v=%b ch=%0d d=%h want ch=%0d", k, d4_out_valid, d4_out_ch, d4_out_data, k % 4);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    d4_mode = 1'b1;
    d4_valid = 4'b1010;
    for (int i = 0; i < N4; i++) d4_data[i*W +: W] = 8'(8'h40 + i);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (d4_ready !== 4'b0010) begin
        errors++;
        $display("FAIL fp_ready k=%0d got %b want 0010", k, d4_ready);
      end
      model_step4();
      @(posedge clk);
      #1;
      checks++;
      if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd1 && d4_out_data === 8'h41)) begin
        errors++;
        $display("FAIL fp_out k=%0d got v=%b ch=%0d d=%h want ch=1 d=41", k, d4_out_valid, d4_out_ch, d4_out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d4_mode = 1'b1;
    d4_valid = 4'b0100;
    d4_data[2*W +: W] = 8'hA5;
    @(negedge clk);
    model_step4();
    @(posedge clk);
    #1;
    d4_out_ready = 1'b0;
    d4_valid = 4'hF;
    for (int i = 0; i < N4; i++) d4_data[i*W +: W] = 8'(8'h60 + i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (d4_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready k=%0d got %b want 0000", k, d4_ready);
      end
      checks++;
      if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd2 && d4_out_data === 8'hA5)) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b ch=%0d d=%h want v=1 ch=2 d=a5", k, d4_out_valid, d4_out_ch, d4_out_data);
      end
      model_step4();
      @(posedge clk);
      #1;
    end
    d4_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d4_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 0001", d4_ready);
    end
    model_step4();
    @(posedge clk);
    #1;
    checks++;
    if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd0 && d4_out_data === 8'h60)) begin
      errors++;
      $display("FAIL bp_release_out got v=%b ch=%0d d=%h want v=1 ch=0 d=60", d4_out_valid, d4_out_ch, d4_out_data);
    end
  endtask

  task automatic test_sparse_wrap_n3();
    logic [2:0] vpat [6] = '{3'b010, 3'b001, 3'b000, 3'b111, 3'b111, 3'b111};
    int         ech  [6] = '{1, 0, 0, 1, 2, 0};
    bit         eov  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int         eptr [6] = '{2, 1, 1, 2, 0, 1};
    do_reset();
    for (int i = 0; i < N3; i++) d3_data[i*W +: W] = 8'(8'h30 + i);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] er;
      d3_valid = vpat[k];
      er = eov[k] ? 3'(1 << ech[k]) : 3'b000;
      @(negedge clk);
      checks++;
      if (d3_ready !== er) begin
        errors++;
        $display("FAIL n3_ready k=%0d got %b want %b", k, d3_ready, er);
      end
      @(posedge clk);
      #1;
      checks++;
      if (!(d3_out_valid === eov[k] && int'(d3_out_ch) == ech[k] && int'(d3_out_data) == 8'h30 + ech[k]
            && int'(u_dut3.ptr) == eptr[k])) begin
        errors++;
        $display("FAIL n3_out k=%0d got v=%b ch=%0d d=%h ptr=%0d want v=%b ch=%0d ptr=%0d",
                 k, d3_out_valid, d3_out_ch, d3_out_data, u_dut3.ptr, eov[k], ech[k], eptr[k]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      d4_valid = 4'($urandom);
      if ($urandom_range(0, 7) == 0) d4_mode = ~d4_mode;
      d4_out_ready = ($urandom_range(0, 3) != 0);
      d4_data = 32'($urandom);
      @(negedge clk);
      checks++;
      if (d4_ready !== exp_ready4()) begin
        errors++;
        $display("FAIL rand_ready k=%0d got %b want %b", k, d4_ready, exp_ready4());
      end
      checks++;
      if (d4_out_valid !== m_ov || (m_ov && (d4_out_data !== m_data || int'(d4_out_ch) != m_ch))
          || int'(u_dut4.ptr) != m_ptr) begin
        errors++;
        $display("FAIL rand_out k=%0d got v=%b d=%h ch=%0d ptr=%0d want v=%b d=%h ch=%0d ptr=%0d",
                 k, d4_out_valid, d4_out_data, d4_out_ch, u_dut4.ptr, m_ov, m_data, m_ch, m_ptr);
      end
      model_step4();
      @(posedge clk);
      #1;
    end
  endtask

`ifdef RR_MUX_FORCE_SEL_EN
  task automatic test_force();
    do_reset();
    f4_en = 1'b1;
    f4_sel = 2'd3;
    d4_valid = 4'hF;
    for (int i = 0; i < N4; i++) d4_data[i*W +: W] = 8'(8'h70 + i);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (d4_ready !== 4'b1000) begin
        errors++;
        $display("FAIL force_ready k=%0d got %b want 1000", k, d4_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (!(d4_out_valid === 1'b1 && d4_out_ch === 2'd3 && d4_out_data === 8'h73 && u_dut4.ptr === 2'd0)) begin
        errors++;
        $display("FAIL force_out k=%0d got v=%b ch=%0d d=%h ptr=%0d want ch=3 d=73 ptr=0",
                 k, d4_out_valid, d4_out_ch, d4_out_data, u_dut4.ptr);
      end
    end
    f3_en = 1'b1;
    f3_sel = 2'd3;
    d3_valid = 3'b111;
    @(negedge clk);
    checks++;
    if (d3_ready !== 3'b000) begin
      errors++;
      $display("FAIL force_oor_ready got %b want 000", d3_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_sparse_wrap_n3();
    test_random();
`ifdef RR_MUX_FORCE_SEL_EN
    test_force();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
